// File: rtl/golomb_best_tracker_pkg.sv
// Shared sizes, FSM encoding and the stored-ruler type for the Golomb best-ruler tracker.
package golomb_best_tracker_pkg;

    localparam int unsigned NUMPOS = 6;   // marks including mark 0; leaf is mark NUMPOS-1
    localparam int unsigned VW     = 8;   // mark value width
    localparam int unsigned NW     = 3;   // mark index width
    localparam int unsigned MAXLEN = 17;  // initial limit
    localparam int unsigned SOLW   = 32;  // solution counter width

    typedef enum logic [1:0] {
        GBT_SEARCH = 2'd0,
        GBT_DRAIN  = 2'd1,
        GBT_STREAM = 2'd2,
        GBT_DONE   = 2'd3
    } gbt_state_t;

    // Element i holds mark i; element NUMPOS-1 is the leaf (ruler length).
    typedef logic [NUMPOS-1:0][VW-1:0] mark_array_t;

endpackage

// File: rtl/golomb_result_streamer.sv
// Streams the stored best ruler mark by mark over a valid/ready handshake.
module golomb_result_streamer
    import golomb_best_tracker_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  mark_array_t       marks,
    input  logic              res_ready,
    output logic              res_valid,
    output logic [NW-1:0]     res_idx,
    output logic [VW-1:0]     res_data,
    output logic              last_xfer_c
);

    logic          xfer_c;
    logic [NW-1:0] idx_nxt_c;

    always_comb begin
        xfer_c      = res_valid & res_ready;
        last_xfer_c = xfer_c & (res_idx == NW'(NUMPOS - 1));
        idx_nxt_c   = res_idx + NW'(1);
    end

    // Index and data only move on an accepted beat, so both hold while ready is low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            res_valid <= 1'b0;
            res_idx   <= '0;
            res_data  <= '0;
        end else if (start) begin
            res_valid <= 1'b1;
            res_idx   <= '0;
            res_data  <= marks[0];
        end else if (last_xfer_c) begin
            res_valid <= 1'b0;
        end else if (xfer_c) begin
            res_idx   <= idx_nxt_c;
            res_data  <= marks[idx_nxt_c];
        end
    end

endmodule

// File: rtl/golomb_best_tracker.sv
// Keeps the shortest accepted Golomb ruler, shrinks the counters' limit, and streams the result.
// Optional feature: define GOLOMB_SOLCOUNT_EN to add the saturating sol_count output.
module golomb_best_tracker
    import golomb_best_tracker_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 success,
    input  logic [VW-1:0]        leaf_val,
    input  logic [NUMPOS*VW-1:0] marks_in,
    input  logic [NW-1:0]        enabled,
    input  logic                 globalready,
    output logic [VW-1:0]        limit,
    output logic                 best_valid,
    output logic [VW-1:0]        best_len,
    output logic                 done,
`ifdef GOLOMB_SOLCOUNT_EN
    output logic [SOLW-1:0]      sol_count,
`endif
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [NW-1:0]        res_idx,
    output logic [VW-1:0]        res_data
);

    gbt_state_t  state;
    gbt_state_t  state_nxt;
    logic        success_d;
    mark_array_t stored;

    logic succ_edge_c;
    logic capture_c;
    logic exhausted_c;
    logic start_c;
    logic finish_c;
    logic last_xfer_c;

    // The leaf slot of marks_in is replaced by leaf_val.
    logic unused_leaf_slot;
    assign unused_leaf_slot = ^marks_in[VW-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= GBT_SEARCH;
        else       state <= state_nxt;
    end

    always_comb begin
        succ_edge_c = success & ~success_d & (state == GBT_SEARCH);
        capture_c   = succ_edge_c & (leaf_val != '0) & (leaf_val <= limit);
        exhausted_c = globalready & (enabled == '0);
        start_c     = (state == GBT_DRAIN) & best_valid;
        finish_c    = ((state == GBT_DRAIN) & ~best_valid) | last_xfer_c;
        state_nxt   = state;
        unique case (state)
            GBT_SEARCH: if (exhausted_c) state_nxt = GBT_DRAIN;
            GBT_DRAIN:  state_nxt = best_valid ? GBT_STREAM : GBT_DONE;
            GBT_STREAM: if (last_xfer_c) state_nxt = GBT_DONE;
            GBT_DONE:   state_nxt = GBT_DONE;
            default:    state_nxt = GBT_SEARCH;
        endcase
    end

    // Capture path: a new ruler tightens the limit so only strictly shorter ones follow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            success_d  <= 1'b0;
            limit      <= VW'(MAXLEN);
            best_valid <= 1'b0;
            best_len   <= '0;
            stored     <= '0;
            done       <= 1'b0;
        end else begin
            success_d <= success;
            if (capture_c) begin
                for (int unsigned i = 0; i < NUMPOS - 1; i++) begin
                    stored[i] <= marks_in[(NUMPOS - 1 - i) * VW +: VW];
                end
                stored[NUMPOS-1] <= leaf_val;
                best_len         <= leaf_val;
                best_valid       <= 1'b1;
                limit            <= leaf_val - VW'(1);
            end
            if (finish_c) done <= 1'b1;
        end
    end

`ifdef GOLOMB_SOLCOUNT_EN
    // Counts every success edge seen while searching, saturating at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                                sol_count <= '0;
        else if (succ_edge_c && (sol_count != '1)) sol_count <= sol_count + SOLW'(1);
    end
`endif

    golomb_result_streamer u_streamer (
        .clock       (clock),
        .reset       (reset),
        .start       (start_c),
        .marks       (stored),
        .res_ready   (res_ready),
        .res_valid   (res_valid),
        .res_idx     (res_idx),
        .res_data    (res_data),
        .last_xfer_c (last_xfer_c)
    );

endmodule

// File: tb/tb_golomb_best_tracker.sv
// Self-checking bench for golomb_best_tracker: vector table, corner sequences, randomized model run.
module tb_golomb_best_tracker;
    import golomb_best_tracker_pkg::*;

    localparam int unsigned MW = NUMPOS * VW;
    localparam int PH_SEARCH = 0, PH_DRAIN = 1, PH_STREAM = 2, PH_DONE = 3;

    logic          clock, reset, success, globalready, res_ready;
    logic [VW-1:0] leaf_val;
    logic [MW-1:0] marks_in;
    logic [NW-1:0] enabled;
    logic [VW-1:0] limit, best_len, res_data;
    logic          best_valid, done, res_valid;
    logic [NW-1:0] res_idx;
`ifdef GOLOMB_SOLCOUNT_EN
    logic [SOLW-1:0] sol_count;
`endif

    int errors = 0;
    int checks = 0;

    golomb_best_tracker dut (
        .clock       (clock),
        .reset       (reset),
        .success     (success),
        .leaf_val    (leaf_val),
        .marks_in    (marks_in),
        .enabled     (enabled),
        .globalready (globalready),
        .limit       (limit),
        .best_valid  (best_valid),
        .best_len    (best_len),
        .done        (done),
`ifdef GOLOMB_SOLCOUNT_EN
        .sol_count   (sol_count),
`endif
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_idx     (res_idx),
        .res_data    (res_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // m[0] in the MSBs; the leaf slot carries junk that must be ignored.
    function automatic logic [MW-1:0] pack_marks(input int a, input int b, input int c,
                                                 input int d, input int e);
        return {VW'(a), VW'(b), VW'(c), VW'(d), VW'(e), VW'(8'hAA)};
    endfunction

    task automatic do_reset();
        reset = 1'b1; success = 1'b0; leaf_val = '0; marks_in = '0;
        enabled = '0; globalready = 1'b0; res_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_limit", limit, MAXLEN);
        chk("rst_best_valid", best_valid, 0);
        chk("rst_best_len", best_len, 0);
        chk("rst_done", done, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_idx", res_idx, 0);
        chk("rst_res_data", res_data, 0);
`ifdef GOLOMB_SOLCOUNT_EN
        chk("rst_sol_count", sol_count, 0);
`endif
        reset = 1'b0;
    endtask

    // Drains a stream already in progress; toggle gives ready 1,0,1,0...
    task automatic stream_out(input int exp0, input int exp1, input int exp2, input int exp3,
                              input int exp4, input int exp5, input bit toggle);
        int exp_v [NUMPOS];
        int idx = 0;
        int cyc = 0;
        bit rdy;
        exp_v = '{exp0, exp1, exp2, exp3, exp4, exp5};
        while (idx < int'(NUMPOS) && cyc < 60) begin
            chk("stream_valid", res_valid, 1);
            chk("stream_done_low", done, 0);
            chk("stream_idx", res_idx, idx);
            chk("stream_data", res_data, exp_v[idx]);
            rdy = toggle ? (cyc % 2 == 0) : 1'b1;
            res_ready = rdy;
            step();
            if (rdy) idx++;
            cyc++;
        end
        res_ready = 1'b0;
        chk("stream_beats", idx, NUMPOS);
        chk("stream_end_done", done, 1);
        chk("stream_end_valid", res_valid, 0);
    endtask

    typedef struct {
        logic          s;
        logic [VW-1:0] leaf;
        logic [MW-1:0] marks;
        logic [NW-1:0] en;
        logic          gr;
        int            e_limit;
        int            e_bv;
        int            e_bl;
        int            e_sol;
    } vec_t;

    function automatic vec_t mk(input logic s, input int leaf, input logic [MW-1:0] marks,
                                input int en, input logic gr, input int el, input int ebv,
                                input int ebl, input int esol);
        vec_t v;
        v.s = s; v.leaf = VW'(leaf); v.marks = marks; v.en = NW'(en); v.gr = gr;
        v.e_limit = el; v.e_bv = ebv; v.e_bl = ebl; v.e_sol = esol;
        return v;
    endfunction

    // Behavioural reference: best ruler, limit, and the queue of marks still to stream.
    int          m_phase, m_limit, m_len;
    bit          m_valid, m_done, m_prev;
    int unsigned m_sol;
    int          m_best [NUMPOS];
    int          m_stream [$];

    task automatic model_reset();
        m_phase = PH_SEARCH; m_limit = MAXLEN; m_len = 0; m_valid = 0; m_done = 0;
        m_prev = 0; m_sol = 0; m_stream = {};
        for (int i = 0; i < int'(NUMPOS); i++) m_best[i] = 0;
    endtask

    task automatic model_step();
        int  ph0;
        bit  edge_s;
        ph0 = m_phase;
        edge_s = success && !m_prev && ph0 == PH_SEARCH;
        if (edge_s && m_sol != 32'hFFFF_FFFF) m_sol++;
        if (edge_s && leaf_val != 0 && int'(leaf_val) <= m_limit) begin
            for (int i = 0; i < int'(NUMPOS) - 1; i++)
                m_best[i] = int'(marks_in[(int'(NUMPOS) - 1 - i) * VW +: VW]);
            m_best[NUMPOS-1] = int'(leaf_val);
            m_len = int'(leaf_val);
            m_limit = int'(leaf_val) - 1;
            m_valid = 1;
        end
        case (ph0)
            PH_SEARCH: if (globalready && enabled == 0) m_phase = PH_DRAIN;
            PH_DRAIN: begin
                if (m_valid) begin
                    m_phase = PH_STREAM;
                    m_stream = {};
                    for (int i = 0; i < int'(NUMPOS); i++) m_stream.push_back(m_best[i]);
                end else begin
                    m_phase = PH_DONE;
                    m_done = 1;
                end
            end
            PH_STREAM: begin
                if (res_ready) begin
                    void'(m_stream.pop_front());
                    if (m_stream.size() == 0) begin
                        m_phase = PH_DONE;
                        m_done = 1;
                    end
                end
            end
            default: ;
        endcase
        m_prev = success;
    endtask

    initial begin
        vec_t tv [$];
        logic [MW-1:0] ma, mb, mc, md, me;
        int tail;

        ma = pack_marks(0, 1, 4, 9, 10);
        mb = pack_marks(0, 2, 5, 6, 8);
        mc = pack_marks(0, 2, 3, 7, 8);
        md = pack_marks(0, 1, 3, 7, 12);
        me = pack_marks(0, 3, 4, 9, 11);

        // Captures, held success, over-limit, leaf==limit, leaf==0, non-exhaustion corners.
        tv.push_back(mk(0, 0,  ma, 3, 0, 17, 0, 0,  0));
        tv.push_back(mk(1, 11, ma, 3, 0, 10, 1, 11, 1));
        tv.push_back(mk(1, 11, ma, 3, 0, 10, 1, 11, 1));
        tv.push_back(mk(1, 11, mb, 3, 0, 10, 1, 11, 1));
        tv.push_back(mk(1, 11, mb, 3, 0, 10, 1, 11, 1));
        tv.push_back(mk(1, 11, mb, 3, 0, 10, 1, 11, 1));
        tv.push_back(mk(0, 11, mb, 3, 0, 10, 1, 11, 1));
        tv.push_back(mk(1, 12, mb, 3, 0, 10, 1, 11, 2));
        tv.push_back(mk(0, 12, mb, 3, 0, 10, 1, 11, 2));
        tv.push_back(mk(1, 10, mb, 3, 0, 9,  1, 10, 3));
        tv.push_back(mk(0, 10, mb, 3, 0, 9,  1, 10, 3));
        tv.push_back(mk(1, 0,  mb, 3, 0, 9,  1, 10, 4));
        tv.push_back(mk(0, 0,  mb, 0, 0, 9,  1, 10, 4));
        tv.push_back(mk(1, 9,  mc, 2, 1, 8,  1, 9,  5));
        tv.push_back(mk(0, 9,  mc, 3, 0, 8,  1, 9,  5));

        do_reset();
        for (int k = 0; k < tv.size(); k++) begin
            success = tv[k].s; leaf_val = tv[k].leaf; marks_in = tv[k].marks;
            enabled = tv[k].en; globalready = tv[k].gr;
            step();
            chk($sformatf("vec%0d_limit", k), limit, tv[k].e_limit);
            chk($sformatf("vec%0d_best_valid", k), best_valid, tv[k].e_bv);
            chk($sformatf("vec%0d_best_len", k), best_len, tv[k].e_bl);
            chk($sformatf("vec%0d_res_valid", k), res_valid, 0);
            chk($sformatf("vec%0d_done", k), done, 0);
`ifdef GOLOMB_SOLCOUNT_EN
            chk($sformatf("vec%0d_sol_count", k), sol_count, tv[k].e_sol);
`endif
        end

        // Exhaustion, a success edge in DRAIN that must be ignored, then toggled-ready stream.
        success = 0; enabled = 0; globalready = 1;
        step();
        chk("drain_res_valid", res_valid, 0);
        success = 1; leaf_val = 5; globalready = 0;
        step();
        chk("drain_ignore_len", best_len, 9);
        stream_out(0, 2, 3, 7, 8, 9, 1'b1);
        success = 0; step();
        success = 1; leaf_val = 3; step();
        chk("done_sticky", done, 1);
        chk("done_ignore_len", best_len, 9);
        chk("done_ignore_limit", limit, 8);
`ifdef GOLOMB_SOLCOUNT_EN
        chk("done_ignore_sol", sol_count, 5);
`endif

        // Exhaustion with nothing captured.
        do_reset();
        enabled = 0; globalready = 1;
        step();
        chk("empty_drain_done", done, 0);
        step();
        chk("empty_done", done, 1);
        chk("empty_valid", res_valid, 0);
        globalready = 0;
        repeat (3) begin
            step();
            chk("empty_valid_hold", res_valid, 0);
            chk("empty_done_hold", done, 1);
        end

        // Capture and exhaustion in the same cycle.
        do_reset();
        success = 1; leaf_val = 15; marks_in = md; enabled = 0; globalready = 1;
        step();
        chk("simul_len", best_len, 15);
        chk("simul_limit", limit, 14);
        chk("simul_valid", res_valid, 0);
        success = 0; globalready = 0;
        step();
        stream_out(0, 1, 3, 7, 12, 15, 1'b0);

        // Reset asserted mid-stream at index 2.
        do_reset();
        success = 1; leaf_val = 13; marks_in = me; enabled = 3;
        step();
        success = 0; enabled = 0; globalready = 1;
        step();
        globalready = 0;
        step();
        chk("mid_valid", res_valid, 1);
        res_ready = 1;
        step(); step();
        res_ready = 0;
        chk("mid_idx", res_idx, 2);
        chk("mid_data", res_data, 4);
        reset = 1;
        #1;
        chk("async_valid", res_valid, 0);
        chk("async_limit", limit, MAXLEN);
        chk("async_best_valid", best_valid, 0);
        chk("async_idx", res_idx, 0);
        chk("async_done", done, 0);
        @(posedge clock); #1;
        reset = 0; enabled = 3;
        success = 1; leaf_val = 6;
        step();
        chk("post_rst_len", best_len, 6);
        chk("post_rst_limit", limit, 5);
        success = 0;

        // Randomized episodes against the reference model.
        for (int ep = 0; ep < 4; ep++) begin
            do_reset();
            model_reset();
            tail = 0;
            for (int cyc = 0; cyc < 400 && tail < 4; cyc++) begin
                success = 1'($urandom_range(0, 1));
                leaf_val = VW'($urandom_range(0, 20));
                marks_in = MW'({$urandom(), $urandom()});
                enabled = NW'($urandom_range(0, 3));
                globalready = ($urandom_range(0, 15) == 0);
                if (cyc >= 150) begin
                    enabled = 0;
                    globalready = 1;
                end
                res_ready = 1'($urandom_range(0, 1));
                model_step();
                step();
                chk("rnd_limit", limit, m_limit);
                chk("rnd_best_len", best_len, m_len);
                chk("rnd_best_valid", best_valid, m_valid);
                chk("rnd_done", done, m_done);
                chk("rnd_res_valid", res_valid, m_phase == PH_STREAM);
                if (m_phase == PH_STREAM) begin
                    chk("rnd_res_idx", res_idx, int'(NUMPOS) - m_stream.size());
                    chk("rnd_res_data", res_data, m_stream[0]);
                end
`ifdef GOLOMB_SOLCOUNT_EN
                chk("rnd_sol_count", sol_count, m_sol);
`endif
                if (m_done) tail++;
            end
            chk("rnd_episode_done", done, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
